// File: rtl/adc_capture_sequencer_pkg.sv
// Shared types and defaults for the four-channel ADC capture sequencer.
package adc_capture_sequencer_pkg;

   localparam int NUM_ADC          = 4;
   localparam int DEF_CLK_DIV      = 2;
   localparam int DEF_FRAME_CLKS   = 16;
   localparam int DEF_SAMPLE_BITS  = 12;
   localparam int DEF_QUIET_CYCLES = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_QUIET
   } state_t;

endpackage

// File: rtl/adc_shift_channel.sv
// One ADC lane: MSB-first serial shift register plus a held output word
// that is refreshed only when load_en is pulsed.
module adc_shift_channel
   import adc_capture_sequencer_pkg::*;
#(
   parameter int SAMPLE_BITS = DEF_SAMPLE_BITS
) (
   input  logic                   clk,
   input  logic                   reset_b,
   input  logic                   shift_en,
   input  logic                   sdata,
   input  logic                   load_en,
   output logic [SAMPLE_BITS-1:0] sample
);

   logic [SAMPLE_BITS-1:0] shreg;

   // NOTE: the shift register is a handful of flops, not a memory, so it is
   // reset along with everything else; sequential state uses <= only.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         shreg  <= '0;
         sample <= '0;
      end else begin
         if (shift_en) shreg <= (shreg << 1) | SAMPLE_BITS'(sdata);
         if (load_en)  sample <= shreg;
      end
   end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Frame sequencer for four SPI ADCs sharing one sclk: chip selects, sclk
// divider, bit counting, per-channel capture and overrun reporting.
module adc_capture_sequencer
   import adc_capture_sequencer_pkg::*;
#(
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int FRAME_CLKS   = DEF_FRAME_CLKS,
   parameter int SAMPLE_BITS  = DEF_SAMPLE_BITS,
   parameter int QUIET_CYCLES = DEF_QUIET_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset_b,
   input  logic                   enable,
   input  logic                   start_tick,
   input  logic [NUM_ADC-1:0]     ch_mask,
   input  logic [NUM_ADC-1:0]     adc_sdata,
   output logic [NUM_ADC-1:0]     cs_n,
   output logic                   sclk,
   output logic [SAMPLE_BITS-1:0] sample0,
   output logic [SAMPLE_BITS-1:0] sample1,
   output logic [SAMPLE_BITS-1:0] sample2,
   output logic [SAMPLE_BITS-1:0] sample3,
   output logic                   sample_valid,
   output logic                   busy,
   output logic                   overrun
);

   localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [5:0] BIT_LAST   = 6'(FRAME_CLKS - 1);
   localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES);

   state_t                             state;
   logic [7:0]                         div_cnt;
   logic [5:0]                         bit_cnt;
   logic [7:0]                         quiet_cnt;
   logic [NUM_ADC-1:0]                 mask_q;
   logic                               idle_entry;
   logic                               shift_en;
   logic                               frame_done;
   logic [NUM_ADC-1:0][SAMPLE_BITS-1:0] samples;

   // Capture happens on the same edge that drives sclk from low to high.
   assign shift_en   = (state == ST_SHIFT) && !sclk && (div_cnt == DIV_LAST);
   assign frame_done = (state == ST_SHIFT) && sclk && (div_cnt == DIV_LAST) &&
                       (bit_cnt == BIT_LAST);

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state        <= ST_IDLE;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         quiet_cnt    <= '0;
         mask_q       <= '0;
         idle_entry   <= 1'b0;
         cs_n         <= '1;
         sclk         <= 1'b1;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         idle_entry   <= 1'b0;

         // The first IDLE cycle still counts as busy for incoming requests.
         if (start_tick && ((state != ST_IDLE) || idle_entry)) overrun <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (start_tick && !idle_entry && enable && (ch_mask != '0)) begin
                  mask_q  <= ch_mask;
                  cs_n    <= ~ch_mask;
                  div_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  sclk    <= 1'b0;
                  state   <= ST_SHIFT;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end

            ST_SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (!sclk) begin
                     sclk <= 1'b1;
                  end else if (bit_cnt == BIT_LAST) begin
                     cs_n         <= '1;
                     sample_valid <= 1'b1;
                     quiet_cnt    <= '0;
                     state        <= ST_QUIET;
                  end else begin
                     bit_cnt <= bit_cnt + 6'd1;
                     sclk    <= 1'b0;
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end

            ST_QUIET: begin
               if (quiet_cnt == QUIET_LAST) begin
                  busy       <= 1'b0;
                  idle_entry <= 1'b1;
                  state      <= ST_IDLE;
               end else begin
                  quiet_cnt <= quiet_cnt + 8'd1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_ADC; i++) begin : g_ch
      adc_shift_channel #(
         .SAMPLE_BITS(SAMPLE_BITS)
      ) u_ch (
         .clk      (clk),
         .reset_b  (reset_b),
         .shift_en (shift_en),
         .sdata    (adc_sdata[i]),
         .load_en  (frame_done && mask_q[i]),
         .sample   (samples[i])
      );
   end

   assign sample0 = samples[0];
   assign sample1 = samples[1];
   assign sample2 = samples[2];
   assign sample3 = samples[3];

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer: a default instance and a fast instance
// (CLK_DIV=1, QUIET_CYCLES=1) checked every cycle against a timing model.
module tb_adc_capture_sequencer;

   localparam int F  = 16;
   localparam int SB = 12;

   int div_p [2] = '{2, 1};
   int qui_p [2] = '{4, 1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_b    [2];
   logic          enable     [2];
   logic          start_tick [2];
   logic [3:0]    ch_mask    [2];
   logic [3:0]    adc_sdata  [2];
   logic [3:0]    cs_n       [2];
   logic          sclk       [2];
   logic [SB-1:0] smp        [2][4];
   logic          sv         [2];
   logic          busy       [2];
   logic          ovr        [2];

   adc_capture_sequencer u_dut0 (
      .clk(clk), .reset_b(reset_b[0]), .enable(enable[0]), .start_tick(start_tick[0]),
      .ch_mask(ch_mask[0]), .adc_sdata(adc_sdata[0]), .cs_n(cs_n[0]), .sclk(sclk[0]),
      .sample0(smp[0][0]), .sample1(smp[0][1]), .sample2(smp[0][2]), .sample3(smp[0][3]),
      .sample_valid(sv[0]), .busy(busy[0]), .overrun(ovr[0])
   );

   adc_capture_sequencer #(.CLK_DIV(1), .FRAME_CLKS(16), .SAMPLE_BITS(12), .QUIET_CYCLES(1)) u_dut1 (
      .clk(clk), .reset_b(reset_b[1]), .enable(enable[1]), .start_tick(start_tick[1]),
      .ch_mask(ch_mask[1]), .adc_sdata(adc_sdata[1]), .cs_n(cs_n[1]), .sclk(sclk[1]),
      .sample0(smp[1][0]), .sample1(smp[1][1]), .sample2(smp[1][2]), .sample3(smp[1][3]),
      .sample_valid(sv[1]), .busy(busy[1]), .overrun(ovr[1])
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model: frame timing by arithmetic ----------------
   logic [F-1:0]  adc_word [2][4];
   bit            has_frame [2];
   int            fr_s      [2];
   logic [3:0]    fr_mask   [2];
   logic [F-1:0]  fr_word   [2][4];
   logic [SB-1:0] m_smp     [2][4];
   bit            m_ovr     [2];

   function automatic int lat(input int k);
      return 1 + div_p[k] + 2 * div_p[k] * F;
   endfunction

   // Requests are refused from the cycle after a start up to and including
   // the first IDLE cycle after QUIET.
   function automatic bit blocked(input int k, input int p);
      return has_frame[k] && (p <= fr_s[k] + lat(k) + qui_p[k] + 1);
   endfunction

   task automatic model_step(input int k, input int p);
      if (!reset_b[k]) begin
         has_frame[k] = 1'b0;
         m_ovr[k]     = 1'b0;
         for (int i = 0; i < 4; i++) m_smp[k][i] = '0;
         return;
      end
      if (start_tick[k]) begin
         if (blocked(k, p)) m_ovr[k] = 1'b1;
         else if (enable[k] && ch_mask[k] != 4'h0) begin
            has_frame[k] = 1'b1;
            fr_s[k]      = p;
            fr_mask[k]   = ch_mask[k];
            for (int i = 0; i < 4; i++) fr_word[k][i] = adc_word[k][i];
         end
      end
      if (has_frame[k] && (p + 1 == fr_s[k] + lat(k)))
         for (int i = 0; i < 4; i++)
            if (fr_mask[k][i]) m_smp[k][i] = fr_word[k][i][SB-1:0];
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) model_step(k, cyc);
      cyc++;
   end

   task automatic compare(input int k);
      logic [3:0]    e_cs;
      logic          e_sclk, e_sv, e_busy, e_ovr;
      logic [SB-1:0] e_smp [4];
      int            rel, l, d;
      e_cs = 4'hF; e_sclk = 1'b1; e_sv = 1'b0; e_busy = 1'b0; e_ovr = 1'b0;
      for (int i = 0; i < 4; i++) e_smp[i] = '0;
      if (reset_b[k]) begin
         e_ovr = m_ovr[k];
         for (int i = 0; i < 4; i++) e_smp[i] = m_smp[k][i];
         if (has_frame[k]) begin
            rel = cyc - fr_s[k];
            l   = lat(k);
            d   = div_p[k];
            if (rel >= 1 && rel <= l - 1) e_cs = ~fr_mask[k];
            if (rel >= 1 + d && rel <= l - 1 && ((rel - 1 - d) % (2 * d)) < d) e_sclk = 1'b0;
            e_sv   = (rel == l);
            e_busy = (rel >= 1 && rel <= l + qui_p[k]);
         end
      end
      check($sformatf("u%0d cs_n", k), 32'(cs_n[k]), 32'(e_cs));
      check($sformatf("u%0d sclk", k), 32'(sclk[k]), 32'(e_sclk));
      check($sformatf("u%0d sample_valid", k), 32'(sv[k]), 32'(e_sv));
      check($sformatf("u%0d busy", k), 32'(busy[k]), 32'(e_busy));
      check($sformatf("u%0d overrun", k), 32'(ovr[k]), 32'(e_ovr));
      for (int i = 0; i < 4; i++)
         check($sformatf("u%0d sample%0d", k, i), 32'(smp[k][i]), 32'(e_smp[i]));
   endtask

   always @(negedge clk) begin
      compare(0);
      compare(1);
   end

   // ---------------- ADC models: next bit presented on each sclk fall ----------------
   int idx [2]       = '{0, 0};
   bit prev_sclk [2] = '{1'b1, 1'b1};

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (&cs_n[k]) idx[k] = 0;
         else if (prev_sclk[k] && !sclk[k] && idx[k] < F) begin
            for (int i = 0; i < 4; i++) adc_sdata[k][i] = adc_word[k][i][F-1-idx[k]];
            idx[k]++;
         end
         prev_sclk[k] = sclk[k];
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_words(input int k, input logic [F-1:0] w0, input logic [F-1:0] w1,
                            input logic [F-1:0] w2, input logic [F-1:0] w3);
      adc_word[k][0] = w0; adc_word[k][1] = w1; adc_word[k][2] = w2; adc_word[k][3] = w3;
   endtask

   // Runs `budget` cycles from now, pulsing start_tick at multiples of `period`
   // (n_starts of them) and at offsets t1/t2, dropping enable at offset t_en.
   task automatic measure(input int k, input int budget, input int period, input int n_starts,
                          input int t1, input int t2, input int t_en,
                          output int lat_o, output int cs0_low, output logic [3:0] ever_low,
                          output int rises, output int n_sv, output int min_gap, output int max_gap);
      int s, last_sv;
      bit prev;
      s = cyc; lat_o = -1; cs0_low = 0; ever_low = 4'h0; rises = 0; n_sv = 0;
      min_gap = 1 << 30; max_gap = -1; last_sv = -1; prev = 1'b1;
      for (int n = 0; n < budget; n++) begin
         start_tick[k] = ((n % period == 0) && (n / period < n_starts)) || n == t1 || n == t2;
         if (n == t_en) enable[k] = 1'b0;
         @(negedge clk);
         if (!cs_n[k][0]) cs0_low++;
         ever_low = ever_low | ~cs_n[k];
         if (sclk[k] && !prev) rises++;
         prev = sclk[k];
         if (sv[k]) begin
            n_sv++;
            if (lat_o < 0) lat_o = cyc - s;
            if (last_sv >= 0) begin
               if (cyc - last_sv < min_gap) min_gap = cyc - last_sv;
               if (cyc - last_sv > max_gap) max_gap = cyc - last_sv;
            end
            last_sv = cyc;
         end
         step();
      end
      start_tick[k] = 1'b0;
   endtask

   int         lat_o, cs0_low, rises, n_sv, min_gap, max_gap;
   logic [3:0] ever_low;

   initial begin
      for (int k = 0; k < 2; k++) begin
         reset_b[k] = 1'b0; enable[k] = 1'b1; start_tick[k] = 1'b0; ch_mask[k] = 4'hF;
         adc_sdata[k] = 4'h0;
         set_words(k, '0, '0, '0, '0);
      end
      step(); step();
      check("reset cs_n", 32'(cs_n[0]), 32'hF);
      check("reset sclk", 32'(sclk[0]), 32'h1);
      check("reset busy", 32'(busy[0]), 32'h0);
      check("reset overrun", 32'(ovr[0]), 32'h0);
      check("reset sample_valid", 32'(sv[0]), 32'h0);
      reset_b[0] = 1'b1; reset_b[1] = 1'b1;
      step(); step();

      // Basic frame with the reference words.
      set_words(0, 16'h0A5C, 16'h03FF, 16'h0000, 16'h0801);
      measure(0, 90, 1000, 1, -1, -1, -1, lat_o, cs0_low, ever_low, rises, n_sv, min_gap, max_gap);
      check("basic latency", 32'(lat_o), 32'd67);
      check("basic cs_n low cycles", 32'(cs0_low), 32'd66);
      check("basic sclk rises", 32'(rises), 32'd16);
      check("basic strobes", 32'(n_sv), 32'd1);
      check("basic sample0", 32'(smp[0][0]), 32'hA5C);
      check("basic sample1", 32'(smp[0][1]), 32'h3FF);
      check("basic sample2", 32'(smp[0][2]), 32'h000);
      check("basic sample3", 32'(smp[0][3]), 32'h801);

      // Partial mask: unselected channels hold and stay deselected.
      set_words(0, 16'h0111, 16'h0111, 16'h0111, 16'h0111);
      measure(0, 90, 1000, 1, -1, -1, -1, lat_o, cs0_low, ever_low, rises, n_sv, min_gap, max_gap);
      set_words(0, 16'hF123, 16'hFFFF, 16'h0456, 16'hABCD);
      ch_mask[0] = 4'b0101;
      measure(0, 90, 1000, 1, -1, -1, -1, lat_o, cs0_low, ever_low, rises, n_sv, min_gap, max_gap);
      check("mask cs_n ever low", 32'(ever_low), 32'h5);
      check("mask sample0", 32'(smp[0][0]), 32'h123);
      check("mask sample1", 32'(smp[0][1]), 32'h111);
      check("mask sample2", 32'(smp[0][2]), 32'h456);
      check("mask sample3", 32'(smp[0][3]), 32'h111);
      ch_mask[0] = 4'hF;

      // Requests mid-frame and in QUIET are dropped and flagged.
      measure(0, 90, 1000, 1, 30, 68, -1, lat_o, cs0_low, ever_low, rises, n_sv, min_gap, max_gap);
      check("overrun strobes", 32'(n_sv), 32'd1);
      check("overrun flag", 32'(ovr[0]), 32'h1);
      set_words(0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
      measure(0, 90, 1000, 1, -1, -1, -1, lat_o, cs0_low, ever_low, rises, n_sv, min_gap, max_gap);
      check("after overrun latency", 32'(lat_o), 32'd67);
      check("after overrun sample2", 32'(smp[0][2]), 32'hABC);
      check("overrun sticky", 32'(ovr[0]), 32'h1);

      // Reset mid-frame aborts the frame.
      start_tick[0] = 1'b1;
      step();
      start_tick[0] = 1'b0;
      for (int n = 1; n < 40; n++) step();
      #1 reset_b[0] = 1'b0;
      #1;
      check("abort cs_n", 32'(cs_n[0]), 32'hF);
      check("abort sclk", 32'(sclk[0]), 32'h1);
      check("abort busy", 32'(busy[0]), 32'h0);
      check("abort overrun", 32'(ovr[0]), 32'h0);
      check("abort sample0", 32'(smp[0][0]), 32'h0);
      step(); step();
      reset_b[0] = 1'b1;
      measure(0, 60, 1000, 0, -1, -1, -1, lat_o, cs0_low, ever_low, rises, n_sv, min_gap, max_gap);
      check("abort strobes", 32'(n_sv), 32'd0);
      set_words(0, 16'h0FED, 16'h0CBA, 16'h0987, 16'h0654);
      measure(0, 90, 1000, 1, -1, -1, -1, lat_o, cs0_low, ever_low, rises, n_sv, min_gap, max_gap);
      check("post-reset latency", 32'(lat_o), 32'd67);
      check("post-reset sample3", 32'(smp[0][3]), 32'h654);

      // Enable dropped mid-frame; later starts with enable low are ignored silently.
      measure(0, 90, 1000, 1, -1, -1, 10, lat_o, cs0_low, ever_low, rises, n_sv, min_gap, max_gap);
      check("enable-drop latency", 32'(lat_o), 32'd67);
      measure(0, 90, 1000, 1, -1, -1, -1, lat_o, cs0_low, ever_low, rises, n_sv, min_gap, max_gap);
      check("disabled strobes", 32'(n_sv), 32'd0);
      check("disabled cs_n", 32'(ever_low), 32'h0);
      check("disabled overrun", 32'(ovr[0]), 32'h0);
      enable[0] = 1'b1;

      // Fast instance: back-to-back starts at the earliest accepted cycle.
      set_words(1, 16'h0321, 16'h0654, 16'h0987, 16'h0CBA);
      measure(1, 160, 37, 4, -1, -1, -1, lat_o, cs0_low, ever_low, rises, n_sv, min_gap, max_gap);
      check("fast latency", 32'(lat_o), 32'd34);
      check("fast strobes", 32'(n_sv), 32'd4);
      check("fast min spacing", 32'(min_gap), 32'd37);
      check("fast max spacing", 32'(max_gap), 32'd37);
      check("fast overrun", 32'(ovr[1]), 32'h0);
      measure(1, 80, 1000, 1, 36, -1, -1, lat_o, cs0_low, ever_low, rises, n_sv, min_gap, max_gap);
      check("idle-entry strobes", 32'(n_sv), 32'd1);
      check("idle-entry overrun", 32'(ovr[1]), 32'h1);

      // Randomized traffic on both instances.
      for (int n = 0; n < 4000; n++) begin
         for (int k = 0; k < 2; k++) begin
            if (!reset_b[k]) reset_b[k] = 1'b1;
            else if ($urandom_range(0, 1499) == 0) reset_b[k] = 1'b0;
            if (!has_frame[k] || cyc > fr_s[k] + lat(k) + qui_p[k] + 1)
               for (int i = 0; i < 4; i++) adc_word[k][i] = 16'($urandom);
            start_tick[k] = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 49) == 0) enable[k] = ~enable[k];
            ch_mask[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/adc_capture_sequencer.md
ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 2: sclk half-period in clk cycles (legal range 1..255).
REQ-002 Parameter FRAME_CLKS, default 16: sclk pulses per conversion frame (legal range SAMPLE_BITS..32).
REQ-003 Parameter SAMPLE_BITS, default 12: valid sample bits (the final SAMPLE_BITS bits of the frame).
REQ-004 Parameter QUIET_CYCLES, default 4: minimum clk cycles with cs_n high between frames (legal range 1..255).
REQ-005 clk  in  1  the block's only clock; all logic is on the rising edge.
REQ-006 reset_b  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  when low, the block accepts no new frames.
REQ-008 start_tick  in  1  one-cycle conversion request (sample-rate strobe).
REQ-009 ch_mask  in  4  per-channel enable; sampled at frame start.
REQ-010 adc_sdata  in  4  serial data, bit i from ADC i.
REQ-011 cs_n  out  4  per-ADC chip select, active low.
REQ-012 sclk  out  1  shared SPI clock; idles high.
REQ-013 sample0..sample3  out  SAMPLE_BITS each  last captured word per channel.
REQ-014 sample_valid  out  1  one-cycle strobe; sample0..3 are updated in the same cycle.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 overrun  out  1  sticky flag: start_tick arrived while busy; cleared only by reset.

Function
REQ-017 States: IDLE, SETUP, SHIFT, QUIET; state transitions occur only on a clk edge.
REQ-018 IDLE->SETUP when start_tick && enable && (ch_mask != 0); the block latches ch_mask, and cs_n[i] goes low for each latched bit on the next cycle.
REQ-019 IDLE with start_tick && enable && ch_mask==0: no frame, no strobe, state remains IDLE.
REQ-020 SETUP lasts CLK_DIV cycles with sclk high, then -> SHIFT.
REQ-021 SHIFT: for each of FRAME_CLKS bits, sclk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-022 On each sclk low->high transition, adc_sdata[i] is shifted MSB-first into channel i's SAMPLE_BITS shift register; earlier leading bits fall off.
REQ-023 After the FRAME_CLKS-th high phase completes: cs_n goes all-high, sample_valid pulses, sampleN updates for masked-in channels only (others hold), state -> QUIET.
REQ-024 Frame latency from the start_tick cycle to the sample_valid cycle is 1 + CLK_DIV + 2*CLK_DIV*FRAME_CLKS cycles.
REQ-025 QUIET lasts QUIET_CYCLES cycles with cs_n high and sclk high, then -> IDLE.
REQ-026 start_tick in SETUP/SHIFT/QUIET: ignored (not queued), overrun set the same cycle.
REQ-027 start_tick coinciding with the IDLE-entry cycle: treated as busy (ignored, overrun set).
REQ-028 enable deasserted mid-frame: the current frame completes normally; deassertion blocks only new starts.
REQ-029 ch_mask and enable changes mid-frame have no effect on the running frame.
REQ-030 Bit and divider counters are sized to their parameter maximums and never wrap within a frame.

Reset
REQ-031 reset_b low asynchronously forces: state IDLE, cs_n 4'hF, sclk 1, sample0..3 0, sample_valid 0, busy 0, overrun 0, all counters and shift registers 0.
REQ-032 Reset mid-frame aborts the frame and produces no sample_valid; the first frame after release behaves as after power-up.

Structure
REQ-033 The shared package holds the state enumeration, default parameter values, and the NUM_ADC=4 constant.
REQ-034 A single sub-module, adc_shift_channel (one SAMPLE_BITS shift register plus load enable), is instantiated four times; the FSM and dividers live in the top of this block.

Verification
REQ-035 Defaults; mask 4'hF; ADC models drive 4 zeros then 12'hA5C/12'h3FF/12'h000/12'h801; one start_tick -> sample_valid exactly 67 cycles later with matching words, cs_n low for exactly 66 cycles, 16 sclk rising edges.
REQ-036 Mask 4'b0101, prior samples 12'h111 on all channels -> only sample0 and sample2 update, sample1 and sample3 stay 12'h111, cs_n[1] and cs_n[3] stay high.
REQ-037 start_tick at cycle 30 of a frame and in QUIET -> overrun=1, no second frame, exactly one sample_valid; start_tick after IDLE is reached -> new frame.
REQ-038 reset_b pulsed low at cycle 40 of a frame -> outputs at reset values immediately, no sample_valid, next start produces a correct frame.
REQ-039 enable dropped at cycle 10 -> frame completes at cycle 67, and a start_tick while enable is low is ignored without setting overrun.
REQ-040 CLK_DIV=1, QUIET_CYCLES=1, back-to-back start_tick at the earliest legal cycle -> sample_valid spacing of 37 cycles, no overrun.
